// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler: steps a song pattern and spawns notes into three lanes
// of three slots each. Active slots advance one row per motion tick. A slot
// retires as a miss after it passes Y_MAX, or as a hit when its lane button is
// pressed while the slot is inside the hit window.
module note_lane_scheduler #(
  parameter int Y_MAX   = 520,
  parameter int SPACING = 32,
  parameter int PAT_LEN = 8,
  parameter int HIT_LO  = 440,
  parameter int HIT_HI  = 480
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        move_tick,
  input  logic [2:0]  btn_hit,
  input  logic [2:0]  pat_data,
  output logic [7:0]  pat_addr,
  output logic [89:0] pos_flat,
  output logic [8:0]  active,
  output logic [2:0]  hit,
  output logic [2:0]  miss,
  output logic [2:0]  overflow,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count,
  output logic [1:0]  state,
  output logic        done
);

  localparam int DIV_W = $clog2(SPACING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         pos_q [9];
  logic [9:0]         pos_d [9];
  logic [8:0]         active_q, active_d;
  logic [7:0]         pat_addr_q, pat_addr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         hit_q, hit_d;
  logic [2:0]         miss_q, miss_d;
  logic [2:0]         overflow_q, overflow_d;
  logic [7:0]         hit_count_q, hit_count_d;
  logic [7:0]         miss_count_q, miss_count_d;
  logic               done_q, done_d;

  logic [8:0]         cand;       // slot may be judged as a hit this cycle
  logic [8:0]         hit_slot;   // the single winning slot per pressed lane
  logic [8:0]         spawn_slot; // lowest-index free slot per lane
  logic [2:0]         lane_full;
  logic [2:0]         lane_req;   // pattern bits reordered to lane index
  logic               judging;

  // Pattern word has red in bit2; lanes are numbered with red as lane 0.
  assign lane_req = {pat_data[0], pat_data[1], pat_data[2]};
  assign judging  = (state_q == S_RUN) || (state_q == S_DRAIN);

  // Adds the number of pulsed lanes to a count, clamping at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] p);
    logic [9:0] sum;
    sum = {2'b00, c} + {9'd0, p[0]} + {9'd0, p[1]} + {9'd0, p[2]};
    return (sum > 10'd255) ? 8'd255 : sum[7:0];
  endfunction

  // Hit judgement on pre-tick positions: deepest in-window slot wins, ties to lowest index.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    cand     = '0;
    hit_slot = '0;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 3; j++) begin
        cand[3*l+j] = judging && btn_hit[l] && active_q[3*l+j] &&
                      (pos_q[3*l+j] >= 10'(HIT_LO)) && (pos_q[3*l+j] <= 10'(HIT_HI));
      end
    end
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 3; j++) begin
        hit_slot[3*l+j] = cand[3*l+j];
        for (int k = 0; k < 3; k++) begin
          if (k != j && cand[3*l+k] &&
              ((pos_q[3*l+k] > pos_q[3*l+j]) ||
               (pos_q[3*l+k] == pos_q[3*l+j] && k < j))) begin
            hit_slot[3*l+j] = 1'b0;
          end
        end
      end
    end
  end

  // Spawn target per lane: lowest-index slot that was free at the start of the cycle.
  always_comb begin
    spawn_slot = '0;
    lane_full  = '0;
    for (int l = 0; l < 3; l++) begin
      lane_full[l] = &active_q[3*l +: 3];
      for (int j = 0; j < 3; j++) begin
        spawn_slot[3*l+j] = ~active_q[3*l+j];
        for (int k = 0; k < j; k++) begin
          if (!active_q[3*l+k]) spawn_slot[3*l+j] = 1'b0;
        end
      end
    end
  end

  // Next-state logic: FSM, slot motion/retire/hit, spawning and counters.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    active_d     = active_q;
    pat_addr_d   = pat_addr_q;
    div_d        = div_q;
    hit_d        = '0;
    miss_d       = '0;
    overflow_d   = '0;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          pat_addr_d   = '0;
          div_d        = '0;
          active_d     = '0;
          hit_count_d  = '0;
          miss_count_d = '0;
          for (int s = 0; s < 9; s++) pos_d[s] = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        for (int l = 0; l < 3; l++) begin
          for (int j = 0; j < 3; j++) begin
            if (hit_slot[3*l+j]) begin
              active_d[3*l+j] = 1'b0;
              pos_d[3*l+j]    = '0;
              hit_d[l]        = 1'b1;
            end else if (move_tick && active_q[3*l+j]) begin
              if (pos_q[3*l+j] == 10'(Y_MAX)) begin
                active_d[3*l+j] = 1'b0;
                pos_d[3*l+j]    = '0;
                miss_d[l]       = 1'b1;
              end else begin
                pos_d[3*l+j] = pos_q[3*l+j] + 10'd1;
              end
            end
          end
        end

        if (state_q == S_RUN && move_tick) begin
          if (div_q == '0) begin
            for (int l = 0; l < 3; l++) begin
              if (lane_req[l]) begin
                if (lane_full[l]) overflow_d[l] = 1'b1;
                for (int j = 0; j < 3; j++) begin
                  if (spawn_slot[3*l+j]) begin
                    active_d[3*l+j] = 1'b1;
                    pos_d[3*l+j]    = '0;
                  end
                end
              end
            end
            if (pat_addr_q == 8'(PAT_LEN - 1)) state_d = S_DRAIN;
            else                               pat_addr_d = pat_addr_q + 8'd1;
          end
          div_d = (div_q == DIV_W'(SPACING - 1)) ? '0 : div_q + 1'b1;
        end

        if (state_q == S_DRAIN && active_q == '0) state_d = S_DONE;

        hit_count_d  = sat_add(hit_count_q, hit_d);
        miss_count_d = sat_add(miss_count_q, miss_d);
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      // NOTE: the slot position array is reset too, since the pixel logic reads it directly.
      for (int s = 0; s < 9; s++) pos_q[s] <= '0;
      active_q     <= '0;
      pat_addr_q   <= '0;
      div_q        <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      overflow_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      for (int s = 0; s < 9; s++) pos_q[s] <= pos_d[s];
      active_q     <= active_d;
      pat_addr_q   <= pat_addr_d;
      div_q        <= div_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      overflow_q   <= overflow_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      done_q       <= done_d;
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_pos
    assign pos_flat[10*g +: 10] = pos_q[g];
  end

  assign pat_addr   = pat_addr_q;
  assign active     = active_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign overflow   = overflow_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule
